// File: rtl/data_mem_responder.sv
// data_mem_responder: multicycle data-memory responder for the rdMem/wrMem
// strobe interface. Each request is latched once, held for LAT wait states,
// then performed against an internal word array. Completion is a one-cycle ack.
module data_mem_responder #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdMem,
    input  logic              wrMem,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE, HOLD} state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic [31:0]         req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic                req_rd;
    logic                req_wr;

    // Word array; intentionally outside reset so a reset never alters contents.
    logic [DATA_W-1:0]   mem [0:(1<<ADDR_W)-1];

    logic                strobe;
    logic [31:0]         cur_addr;
    logic [DATA_W-1:0]   cur_wdata;
    logic                cur_rd;
    logic                cur_wr;
    logic                cur_err;
    logic                done_now;
    logic                mem_we;
    logic [ADDR_W-1:0]   idx;

    // Select the request being completed. With LAT=0 the access completes on
    // the latching edge itself, so the live inputs stand in for the latches.
    always_comb begin
        strobe    = rdMem | wrMem;
        cur_addr  = req_addr;
        cur_wdata = req_wdata;
        cur_rd    = req_rd;
        cur_wr    = req_wr;
        if (state == IDLE) begin
            cur_addr  = addr;
            cur_wdata = wdata;
            cur_rd    = rdMem;
            cur_wr    = wrMem;
        end
        done_now = ((state == IDLE) && strobe && (LAT == 0)) ||
                   ((state == WAIT) && (cnt == 4'd1));
        cur_err  = (cur_addr[1:0] != 2'b00) ||
                   ((cur_addr >> (ADDR_W + 2)) != 32'd0) ||
                   (cur_rd && cur_wr);
        idx      = cur_addr[ADDR_W+1:2];
        mem_we   = done_now && cur_wr && !cur_err;
    end

    // Control FSM with registered outputs; reset abandons any pending access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_addr  <= 32'd0;
            req_wdata <= '0;
            req_rd    <= 1'b0;
            req_wr    <= 1'b0;
            rdata     <= '0;
            ack       <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            ack <= 1'b0;
            if (done_now) begin
                ack <= 1'b1;
                err <= cur_err;
                if (cur_err)
                    rdata <= '0;
                else if (cur_rd)
                    rdata <= mem[idx];
            end
            case (state)
                IDLE: begin
                    if (strobe) begin
                        req_addr  <= addr;
                        req_wdata <= wdata;
                        req_rd    <= rdMem;
                        req_wr    <= wrMem;
                        cnt       <= 4'(LAT);
                        busy      <= 1'b1;
                        state     <= (LAT == 0) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= DONE;
                end
                DONE: state <= HOLD;
                HOLD: begin
                    // A strobe still high after ack must not start a second access.
                    if (!strobe) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Array write, committed on the same edge that raises ack.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[idx] <= cur_wdata;
    end

endmodule
